// File: rtl/paddsb_seq_if.sv
// Handshake and data bundle for paddsb_seq: request side drives start/A/B,
// the sequencer returns busy/done and the four-lane result.

interface paddsb_seq_if;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] Sum;
    logic [3:0]  sat;

    modport master (output start, A, B, input busy, done, Sum, sat);
    modport slave  (input start, A, B, output busy, done, Sum, sat);
endinterface

// File: rtl/paddsb_seq.sv
// Four-lane signed nibble saturating add, time-multiplexed over one shared
// 4-bit saturating adder, one lane per cycle, LSB lane first.

module sat_nib_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       sat,
    output logic       cout
);
    logic [4:0] raw;
    logic       ovf;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        ovf  = (a[3] == b[3]) && (raw[3] != a[3]);
        cout = raw[4];
        sat  = ovf;
        s    = ovf ? (a[3] ? 4'b1000 : 4'b0111) : raw[3:0];
    end
endmodule

// state | meaning
// IDLE  | waiting for start; busy=0, done=0
// RUN   | one lane per cycle through the shared adder, cnt selects lane
// DONE  | one-cycle done pulse; start here is accepted like in IDLE
module paddsb_seq (
    input  logic         clk,
    input  logic         rst_n,
    paddsb_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic [15:0] sum_q, sum_d;
    logic [3:0]  sat_q, sat_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [3:0]  lane_a, lane_b, lane_s;
    logic        lane_sat;
    logic        lane_cout_unused;

    assign lane_a = op_a_q[{cnt_q, 2'b00} +: 4];
    assign lane_b = op_b_q[{cnt_q, 2'b00} +: 4];

    // Lane carry-out is dropped: lanes are independent signed nibbles.
    sat_nib_add u_add (
        .a    (lane_a),
        .b    (lane_b),
        .cin  (1'b0),
        .s    (lane_s),
        .sat  (lane_sat),
        .cout (lane_cout_unused)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        sat_d   = sat_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    op_a_d  = bus.A;
                    op_b_d  = bus.B;
                    cnt_d   = 2'd0;
                    sat_d   = 4'h0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[{cnt_q, 2'b00} +: 4] = lane_s;
                sat_d[cnt_q]               = lane_sat;
                if (cnt_q == 2'd3) begin
                    cnt_d   = 2'd0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 2'd1;
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            op_a_q  <= 16'h0000;
            op_b_q  <= 16'h0000;
            sum_q   <= 16'h0000;
            sat_q   <= 4'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            sat_q   <= sat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Sum  = sum_q;
    assign bus.sat  = sat_q;
endmodule

// File: tb/tb_paddsb_seq.sv
// Bench for paddsb_seq: lane-arithmetic model with latency tracking checked
// every cycle, plus directed vectors with literal expected results.

module tb_paddsb_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    paddsb_seq_if bus ();

    paddsb_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_add(input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] s, output logic [3:0] st);
        int x, y, r;
        s  = 16'h0000;
        st = 4'h0;
        for (int i = 0; i < 4; i++) begin
            x = int'($signed(a[4*i +: 4]));
            y = int'($signed(b[4*i +: 4]));
            r = x + y;
            if (r > 7) begin
                r = 7;
                st[i] = 1'b1;
            end else if (r < -8) begin
                r = -8;
                st[i] = 1'b1;
            end
            s[4*i +: 4] = r[3:0];
        end
    endfunction

    // age = cycles since acceptance: 1..4 busy, 5 = done cycle, 0 = idle
    int          age = 0;
    logic [15:0] pend_sum, exp_sum;
    logic [3:0]  pend_sat, exp_sat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age = 0;
        end else if (bus.start && (age == 0 || age == 5)) begin
            model_add(bus.A, bus.B, pend_sum, pend_sat);
            age = 1;
        end else if (age >= 1 && age <= 3) begin
            age = age + 1;
        end else if (age == 4) begin
            age     = 5;
            exp_sum = pend_sum;
            exp_sat = pend_sat;
        end else begin
            age = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 32'(bus.busy), 32'(age >= 1 && age <= 4));
            chk("done", 32'(bus.done), 32'(age == 5));
            if (age == 5) begin
                chk("model_sum", 32'(bus.Sum), 32'(exp_sum));
                chk("model_sat", 32'(bus.sat), 32'(exp_sat));
            end
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] es, input logic [3:0] et,
                          input int poke, input string tag);
        int cyc = 0;
        int nb  = 0;
        bit got = 1'b0;
        @(negedge clk); #2;
        bus.start = 1'b1; bus.A = a; bus.B = b;
        @(posedge clk); #2;
        bus.start = 1'b0; bus.A = ~a; bus.B = ~b;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) nb++;
            got = bus.done;
            if (cyc == poke) begin
                #2; bus.start = 1'b1; bus.A = 16'h7777; bus.B = 16'h1111;
            end else if (cyc == poke + 1) begin
                #2; bus.start = 1'b0;
            end
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd5);
        chk({tag, "_busy_cycles"}, 32'(nb), 32'd4);
        chk({tag, "_sum"}, 32'(bus.Sum), 32'(es));
        chk({tag, "_sat"}, 32'(bus.sat), 32'(et));
    endtask

    int n;
    bit seen;

    initial begin
        bus.start = 1'b0; bus.A = 16'h0000; bus.B = 16'h0000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum",  32'(bus.Sum),  32'h0);
        chk("rst_sat",  32'(bus.sat),  32'h0);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);

        run_op(16'h1234, 16'h1111, 16'h2345, 4'h0, 0, "basic");
        run_op(16'h7777, 16'h1111, 16'h7777, 4'hF, 0, "pos_sat");
        run_op(16'h8888, 16'hFFFF, 16'h8888, 4'hF, 0, "neg_sat");
        run_op(16'hF0A5, 16'h8F3B, 16'h8FD0, 4'h8, 0, "mixed");
        run_op(16'h7F80, 16'h1111, 16'h7091, 4'h8, 2, "ignore_start");

        // start held through DONE: second op must begin with no idle bubble
        @(negedge clk); #2;
        bus.start = 1'b1; bus.A = 16'h1234; bus.B = 16'h1111;
        @(posedge clk); #2;
        bus.A = 16'h8888; bus.B = 16'hFFFF;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin @(negedge clk); n++; seen = bus.done; end
        chk("b2b_first_latency", 32'(n), 32'd5);
        chk("b2b_first_sum", 32'(bus.Sum), 32'h2345);
        chk("b2b_first_sat", 32'(bus.sat), 32'h0);
        @(posedge clk); #2;
        bus.start = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin @(negedge clk); n++; seen = bus.done; end
        chk("b2b_done_gap", 32'(n), 32'd5);
        chk("b2b_second_sum", 32'(bus.Sum), 32'h8888);
        chk("b2b_second_sat", 32'(bus.sat), 32'hF);

        run_op(16'h7F80, 16'h1111, 16'h7091, 4'h8, 0, "pre_reset");

        // abort after lane-1 edge: lanes 0/1 new, lanes 2/3 keep 0x70 from before
        @(negedge clk); #2;
        bus.start = 1'b1; bus.A = 16'h7777; bus.B = 16'h1111;
        @(posedge clk); #2;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        chk("partial_sum", 32'(bus.Sum), 32'h7077);
        chk("partial_sat", 32'(bus.sat), 32'h3);
        chk("partial_busy", 32'(bus.busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_sum",  32'(bus.Sum),  32'h0);
        chk("abort_sat",  32'(bus.sat),  32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_reset_sum", 32'(bus.Sum), 32'h0);

        run_op(16'h1234, 16'h1111, 16'h2345, 4'h0, 0, "after_reset");
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/paddsb_seq.md
PADDSB_SEQ -- requirements
Module: paddsb_seq

Interface
REQ-001 SHALL have a single clock and a reset that is asynchronous and active-low; ports clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a 4-lane nibble saturating add; sampled on rising clk.
REQ-005 A  input  16  operand A, four signed 4-bit lanes; lane i = A[4i+3:4i].
REQ-006 B  input  16  operand B, same lane layout as A.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  one-cycle pulse when Sum and sat are valid.
REQ-009 Sum  output  16  registered lane results; holds until the next accepted start completes lane writes.
REQ-010 sat  output  4  sat[i] = 1 when lane i saturated in the last operation.

Function
REQ-011 SHALL instantiate exactly one shared 4-bit saturating nibble adder (team module), with Cin tied to 0, and time-multiplex it across the four lanes.
REQ-012 SHALL use FSM states IDLE, RUN and DONE.
REQ-013 IDLE: busy=0, done=0; start=1 at an edge latches A and B into internal operand registers, clears lane counter to 0, clears sat to 0, and moves to RUN.
REQ-014 RUN: busy=1; each cycle, the adder sees lane[cnt] of the latched operands; at the edge, Sum[4cnt+3:4cnt] and sat[cnt] are written and cnt is incremented.
REQ-015 RUN processes lanes LSB-first (0,1,2,3); after the lane-3 edge the FSM moves to DONE; RUN lasts exactly 4 cycles.
REQ-016 DONE: done=1, busy=0 for exactly one cycle, then IDLE; start=1 in DONE is accepted exactly as in IDLE, with no idle bubble.
REQ-017 Latency: start accepted at edge N -> done high during the cycle after edge N+4.
REQ-018 start during RUN SHALL be ignored; A and B changes after acceptance SHALL NOT affect the result.
REQ-019 Lane arithmetic: signed 4-bit two's complement add; positive overflow -> 4'b0111; negative overflow -> 4'b1000; otherwise wrap-free sum.
REQ-020 sat[i] SHALL be 1 iff lane operand sign bits are equal and the unsaturated sum sign differs from them.
REQ-021 Lane carry-out from the adder SHALL be discarded; there is no carry between lanes.
REQ-022 Sum lanes not yet written in the current operation SHALL retain their previous values; only done marks Sum as valid.
REQ-023 The lane counter is 2 bits and SHALL NOT wrap back into RUN; exit is by state transition only.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, cnt=0, busy=0, done=0, Sum=16'h0000, sat=4'h0, and operand registers to 0, regardless of clk.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst_n deassertion starts a fresh operation.
REQ-026 After reset release, the block SHALL idle until start.

Verification
REQ-027 A=16'h1234, B=16'h1111, start at edge N -> done high after edge N+4, Sum=16'h2345, sat=4'h0, busy high for 4 cycles.
REQ-028 A=16'h7777, B=16'h1111 -> Sum=16'h7777, sat=4'hF; A=16'h8888, B=16'hFFFF -> Sum=16'h8888, sat=4'hF.
REQ-029 A=16'h7F80, B=16'h1111 -> Sum=16'h7091, sat=4'b1000.
REQ-030 start pulsed during RUN with different A/B -> ignored, original result delivered; start held through DONE -> second operation begins next cycle, done pulses 5 cycles apart.
REQ-031 rst_n pulled low after lane-1 edge of an operation -> busy, done, Sum, and sat go to 0 asynchronously, no done pulse; new start after release yields the correct result.
